// File: rtl/seven_segment_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver:
// hex-to-segment table, scan FSM state encoding and digit-enable polarity helper.
package seven_segment_pkg;

    // Scan FSM state encoding (legacy-compatible constants)
    typedef logic [1:0] scan_state_t;
    localparam scan_state_t ST_IDLE  = 2'd0;
    localparam scan_state_t ST_GUARD = 2'd1;
    localparam scan_state_t ST_SHOW  = 2'd2;

    // Segment patterns, bit order g..a (bit0 = a), active-high
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Pin level for a digit enable: on=1 means lit; inverted for active-low boards
    function automatic logic dig_level(input logic on, input logic active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/hex_to_seven_segment.sv
// Purely combinational 4-bit hex nibble to 7-segment pattern decoder.
module hex_to_seven_segment
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit seven-segment scanner with double-buffered frame data
// and dark guard intervals between digits.
// Optional feature: define SEVEN_SEGMENT_SCANNER_DP_EN to add per-digit decimal points.
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned GUARD          = 16,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
`ifdef SEVEN_SEGMENT_SCANNER_DP_EN
    input  logic [DIGITS-1:0]     dp,
    output logic                  seg_dp,
`endif
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  SHOW_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  GUARD_LAST  = CNT_W'(GUARD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] DIG_ALL_OFF = {DIGITS{DIG_ACTIVE_LOW}};

    scan_state_t          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4*DIGITS-1:0]  shadow_val_q, shadow_val_d, active_val_q, active_val_d;
    logic [DIGITS-1:0]    shadow_blank_q, shadow_blank_d, active_blank_q, active_blank_d;
    logic                 pending_q, pending_d;
    logic [6:0]           segments_q, segments_d;
    logic [DIGITS-1:0]    digit_en_q, digit_en_d;
    logic                 frame_done_q, frame_done_d;
    logic                 enter_show;
    logic                 commit;
    logic [3:0]           cur_nibble;
    logic                 cur_blank;
    logic [6:0]           dec_seg;
`ifdef SEVEN_SEGMENT_SCANNER_DP_EN
    logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
    logic                 seg_dp_q, seg_dp_d;
`endif

    // Scan sequencing: IDLE -> GUARD -> SHOW -> GUARD ..., enable low forces IDLE
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        enter_show   = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_GUARD;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                ST_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d    = ST_SHOW;
                        cnt_d      = '0;
                        enter_show = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d      = ST_GUARD;
                        cnt_d        = '0;
                        idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        frame_done_d = (idx_q == IDX_LAST);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Double buffer: commit only at the start of digit 0 (or at once while stopped)
    always_comb begin
        commit         = pending_q && (!enable || (enter_show && idx_q == '0));
        active_val_d   = commit ? shadow_val_q   : active_val_q;
        active_blank_d = commit ? shadow_blank_q : active_blank_q;
        shadow_val_d   = load ? value      : shadow_val_q;
        shadow_blank_d = load ? blank_mask : shadow_blank_q;
        // A load coinciding with a commit keeps pending set for the next frame
        pending_d      = load ? 1'b1 : (commit ? 1'b0 : pending_q);
`ifdef SEVEN_SEGMENT_SCANNER_DP_EN
        active_dp_d    = commit ? shadow_dp_q : active_dp_q;
        shadow_dp_d    = load ? dp : shadow_dp_q;
`endif
    end

    // Pick the nibble for the digit about to be shown, using freshly committed data
    always_comb begin
        cur_nibble = active_val_d[4*idx_d +: 4];
        cur_blank  = active_blank_d[idx_d];
    end

    hex_to_seven_segment u_decode (
        .nibble   (cur_nibble),
        .segments (dec_seg)
    );

    // Output next-state: derived from the next FSM state so outputs move with it
    always_comb begin
        segments_d = (state_d == ST_SHOW && !cur_blank) ? dec_seg : 7'h00;
        for (int k = 0; k < int'(DIGITS); k++) begin
            digit_en_d[k] = dig_level(state_d == ST_SHOW && idx_d == IDX_W'(k),
                                      DIG_ACTIVE_LOW);
        end
`ifdef SEVEN_SEGMENT_SCANNER_DP_EN
        seg_dp_d = (state_d == ST_SHOW) && !cur_blank && active_dp_d[idx_d];
`endif
    end

    // State, buffers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            shadow_val_q   <= '0;
            shadow_blank_q <= '0;
            active_val_q   <= '0;
            active_blank_q <= '0;
            pending_q      <= 1'b0;
            segments_q     <= 7'h00;
            digit_en_q     <= DIG_ALL_OFF;
            frame_done_q   <= 1'b0;
`ifdef SEVEN_SEGMENT_SCANNER_DP_EN
            shadow_dp_q    <= '0;
            active_dp_q    <= '0;
            seg_dp_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            shadow_val_q   <= shadow_val_d;
            shadow_blank_q <= shadow_blank_d;
            active_val_q   <= active_val_d;
            active_blank_q <= active_blank_d;
            pending_q      <= pending_d;
            segments_q     <= segments_d;
            digit_en_q     <= digit_en_d;
            frame_done_q   <= frame_done_d;
`ifdef SEVEN_SEGMENT_SCANNER_DP_EN
            shadow_dp_q    <= shadow_dp_d;
            active_dp_q    <= active_dp_d;
            seg_dp_q       <= seg_dp_d;
`endif
        end
    end

    assign segments   = segments_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;
`ifdef SEVEN_SEGMENT_SCANNER_DP_EN
    assign seg_dp     = seg_dp_q;
`endif

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Multiplexed N-digit seven-segment display driver: the parametrised successor of the single-digit combinational decoder. It holds a double-buffered frame of DIGITS hex nibbles and time-multiplexes one shared segment bus across DIGITS digit enables. A guard interval between digits suppresses ghosting. It sits between any value-producing datapath and the board's display pins.

## Interface
- DIGITS, 4: number of digits scanned, 1..8.
- SCAN_DIV, 50000: clock cycles each digit is lit, ≥2.
- GUARD, 16: dark cycles between digits, ≥1.
- DIG_ACTIVE_LOW, 1: digit_en polarity; 1 means a lit digit reads 0.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- enable  in  1  scan run; 0 blanks the display.
- load  in  1  one-cycle strobe; captures value and blank_mask into the shadow buffer.
- value  in  4*DIGITS  nibble k (bits 4k+3:4k) is digit k; digit 0 is rightmost.
- blank_mask  in  DIGITS  bit k=1 forces digit k dark.
- segments  out  7  active-high, bit order g..a (bit0=a).
- digit_en  out  DIGITS  one-hot (polarity per DIG_ACTIVE_LOW) digit select.
- frame_done  out  1  one-cycle pulse when digit DIGITS-1 finishes its SHOW period.

## Operation
- Decode covers full hex 0-F. Patterns are a/b/c/d/e/f/g-standard:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - All values are hex of segments[6:0]. Digits 0 and 1 are now decoded, not blank.
- Buffers:
  - load copies value/blank_mask into shadow and sets pending.
  - When pending=1 and the scan enters digit 0 (GUARD→SHOW with idx=0), shadow copies to active and pending clears. This prevents tearing mid-frame.
  - A load in the same cycle as the commit overwrites shadow and leaves pending=1. The new data commits on the next frame.
  - If enable=0, a pending shadow commits immediately on the next cycle.
- FSM states:
  - IDLE: digits off, segments=0.
    - enable=1 → GUARD with idx=0, cnt=0.
  - GUARD: digits off, segments=0, counts GUARD cycles.
    - Then → SHOW.
  - SHOW: digit_en[idx] asserted; segments = decode(active[idx]), or 0 if the blank bit is set. Counts SCAN_DIV cycles.
    - Then → GUARD, with idx = idx+1, wrapping DIGITS-1→0.
  - Any state with enable=0 → IDLE next cycle; idx and cnt reset to 0.
- frame_done pulses on the SHOW→GUARD transition when idx=DIGITS-1.
- Counter width is clog2(max(SCAN_DIV,GUARD)). The index width is clog2(DIGITS), minimum 1.

## Timing
- All outputs are registered and change on the same edge as the state transition that causes them.
- Reset values (rst_n low, immediate): state=IDLE, idx=0, cnt=0, active=0, shadow=0, pending=0, segments=0, frame_done=0.
  - digit_en = all off: all ones if DIG_ACTIVE_LOW=1, else all zeros.
- Reset mid-SHOW darkens the display at once. After reset, the first lit digit appears GUARD+1 cycles after the first enable=1 edge.
- Frame period is DIGITS*(SCAN_DIV+GUARD) cycles.
- At most one digit is ever enabled. No digit is enabled in a cycle where segments is changing between digits.
- load→visible latency: at most one frame plus GUARD cycles.

## Configuration
- SEVEN_SEGMENT_SCANNER_DP_EN defined:
  - Adds input dp [DIGITS-1:0] (captured with load, double-buffered identically) and output seg_dp (1 bit, active-high).
  - seg_dp = dp[idx] in SHOW for non-blanked digits, else 0. Reset value 0.
- Macro undefined: neither port exists and no dp storage is built.

## Structure
- Shared package seven_segment_pkg holds:
  - the 16-entry hex→segment constant table;
  - the FSM state enum (IDLE, GUARD, SHOW);
  - the DIG_ON/DIG_OFF polarity helper function.
- One sub-module, hex_to_seven_segment: a purely combinational 4-bit→7-bit decoder using the package table. The top module instantiates it once on the muxed active nibble.

## Test plan
- Reset/idle:
  - Stimulus: rst_n low, then release with enable=0.
  - Required: segments=0 and digit_en=4'b1111 (DIGITS=4, active-low) for 100 cycles. frame_done never pulses.
- Full hex sweep:
  - Stimulus: SCAN_DIV=4, GUARD=2, load value=16'h3210, enable=1.
  - Required: digit 0 shows 3F, digit 1 shows 06, digit 2 shows 5B, digit 3 shows 4F. Each is lit exactly 4 cycles with 2 dark cycles between. frame_done pulses every 24 cycles.
- Tear-free update:
  - Stimulus: load 16'hABCD while digit 2 is lit.
  - Required: digits 2 and 3 still show the old data this frame. The next frame shows d=5E, C=39, b=7C, A=77.
- Blanking:
  - Stimulus: blank_mask=4'b1000 with value=16'h0042.
  - Required: digit 3 is enabled for its slot with segments=0. The other digits decode normally.
- Enable drop mid-SHOW:
  - Stimulus: deassert enable during digit 1.
  - Required: next cycle, state is IDLE and all digits are off. On re-enable, the scan restarts at digit 0 after GUARD cycles, and a pending load commits.
- Async reset mid-frame:
  - Stimulus: pulse rst_n low between clock edges.
  - Required: outputs go to reset values without waiting for clk; pending and buffers read 0.
